// File: rtl/rob_param_if.sv
// Bundle of dispatch, completion, commit and status signals for the reorder buffer.
// The master side drives dispatch, completions and flush; the slave side is the ROB itself.
interface rob_param_if #(
    parameter int DEPTH    = 16,
    parameter int DPW      = 2,
    parameter int CMW      = 2,
    parameter int NFIN     = 5,
    parameter int REG_SEL  = 5,
    parameter int ADDR_LEN = 32
);
    localparam int IW = $clog2(DEPTH);

    logic [DPW-1:0]          dp_valid;
    logic [DPW*ADDR_LEN-1:0] dp_pc;
    logic [DPW*REG_SEL-1:0]  dp_dst;
    logic [DPW-1:0]          dp_dstvalid;
    logic [DPW-1:0]          dp_isstore;
    logic [DPW-1:0]          dp_isbranch;
    logic                    dp_ready;
    logic [DPW*IW-1:0]       dp_tag;

    logic [NFIN-1:0]         fin_valid;
    logic [NFIN*IW-1:0]      fin_tag;
    logic [NFIN-1:0]         fin_exc;

    logic                    br_valid;
    logic [IW-1:0]           br_tag;
    logic                    br_taken;
    logic [ADDR_LEN-1:0]     br_target;

    logic                    flush;

    logic [CMW-1:0]          cm_valid;
    logic [CMW*IW-1:0]       cm_tag;
    logic [CMW-1:0]          cm_we;
    logic [CMW*REG_SEL-1:0]  cm_dst;
    logic                    cm_store;
    logic                    cm_branch;
    logic [ADDR_LEN-1:0]     cm_br_pc;
    logic                    cm_br_taken;
    logic [ADDR_LEN-1:0]     cm_br_target;

    logic                    exc_valid;
    logic [ADDR_LEN-1:0]     exc_pc;
    logic [IW-1:0]           exc_tag;
    logic [IW:0]             count;
    logic                    empty;

    modport master (
        output dp_valid, dp_pc, dp_dst, dp_dstvalid, dp_isstore, dp_isbranch,
        output fin_valid, fin_tag, fin_exc,
        output br_valid, br_tag, br_taken, br_target, flush,
        input  dp_ready, dp_tag,
        input  cm_valid, cm_tag, cm_we, cm_dst, cm_store, cm_branch,
        input  cm_br_pc, cm_br_taken, cm_br_target,
        input  exc_valid, exc_pc, exc_tag, count, empty
    );

    modport slave (
        input  dp_valid, dp_pc, dp_dst, dp_dstvalid, dp_isstore, dp_isbranch,
        input  fin_valid, fin_tag, fin_exc,
        input  br_valid, br_tag, br_taken, br_target, flush,
        output dp_ready, dp_tag,
        output cm_valid, cm_tag, cm_we, cm_dst, cm_store, cm_branch,
        output cm_br_pc, cm_br_taken, cm_br_target,
        output exc_valid, exc_pc, exc_tag, count, empty
    );
endinterface

// File: rtl/rob_param.sv
// Parameterised reorder buffer: multi-lane in-order dispatch, out-of-order completion,
// in-order multi-lane commit with at most one store/branch per cycle, precise exceptions.
module rob_param #(
    parameter int DEPTH    = 16,
    parameter int DPW      = 2,
    parameter int CMW      = 2,
    parameter int NFIN     = 5,
    parameter int REG_SEL  = 5,
    parameter int ADDR_LEN = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    rob_param_if.slave io
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] READY_MAX = (IW+1)'(DEPTH - DPW);

    logic [IW-1:0]       head;
    logic [IW-1:0]       tail;
    logic [IW:0]         count;
    logic [DEPTH-1:0]    finish;
    logic [DEPTH-1:0]    exc;
    logic [DEPTH-1:0]    brcond;
    logic [DEPTH-1:0]    dstvalid;
    logic [DEPTH-1:0]    isstore;
    logic [DEPTH-1:0]    isbranch;
    logic [ADDR_LEN-1:0] pc      [DEPTH];
    logic [ADDR_LEN-1:0] jmpaddr [DEPTH];
    logic [REG_SEL-1:0]  dst     [DEPTH];

    logic          dp_ready;
    logic          accept;
    logic          exc_block;
    logic          cm_open;
    logic [IW:0]   n_acc;
    logic [IW:0]   n_cm;
    logic [IW-1:0] didx [DPW];
    logic [IW-1:0] cidx [CMW];

    // Tags outside head..head+count-1 belong to squashed or not-yet-dispatched entries.
    function automatic logic in_window(input logic [IW-1:0] tag);
        logic [IW-1:0] off;
        off = tag - head;
        return {1'b0, off} < count;
    endfunction

    assign dp_ready  = (count <= READY_MAX);
    assign accept    = dp_ready && !io.flush;
    assign exc_block = (count != '0) && finish[head] && exc[head];

    assign io.dp_ready  = dp_ready;
    assign io.count     = count;
    assign io.empty     = (count == '0);
    assign io.exc_valid = exc_block;
    assign io.exc_tag   = head;
    assign io.exc_pc    = pc[head];

    always_comb begin
        n_acc     = '0;
        io.dp_tag = '0;
        for (int k = 0; k < DPW; k++) begin
            didx[k] = tail + IW'(k);
            io.dp_tag[k*IW +: IW] = didx[k];
            if (io.dp_valid[k]) n_acc = n_acc + (IW+1)'(1);
        end
    end

    // A commit group stops at the first unfinished/excepting entry or right after a store or branch.
    always_comb begin
        io.cm_valid     = '0;
        io.cm_tag       = '0;
        io.cm_we        = '0;
        io.cm_dst       = '0;
        io.cm_store     = 1'b0;
        io.cm_branch    = 1'b0;
        io.cm_br_pc     = '0;
        io.cm_br_taken  = 1'b0;
        io.cm_br_target = '0;
        n_cm            = '0;
        cm_open         = !io.flush && !exc_block;
        for (int k = 0; k < CMW; k++) begin
            cidx[k] = head + IW'(k);
            if (cm_open && ((IW+1)'(k) < count) && finish[cidx[k]] && !exc[cidx[k]]) begin
                io.cm_valid[k]               = 1'b1;
                io.cm_tag[k*IW +: IW]        = cidx[k];
                io.cm_we[k]                  = dstvalid[cidx[k]];
                io.cm_dst[k*REG_SEL +: REG_SEL] = dst[cidx[k]];
                n_cm                         = n_cm + (IW+1)'(1);
                if (isstore[cidx[k]]) begin
                    io.cm_store = 1'b1;
                    cm_open     = 1'b0;
                end
                if (isbranch[cidx[k]]) begin
                    io.cm_branch    = 1'b1;
                    io.cm_br_pc     = pc[cidx[k]];
                    io.cm_br_taken  = brcond[cidx[k]];
                    io.cm_br_target = jmpaddr[cidx[k]];
                    cm_open         = 1'b0;
                end
            end else begin
                cm_open = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            finish <= '0;
            exc    <= '0;
            brcond <= '0;
        end else if (io.flush) begin
            tail   <= head;
            count  <= '0;
            finish <= '0;
        end else begin
            head  <= head + n_cm[IW-1:0];
            tail  <= tail + (accept ? n_acc[IW-1:0] : '0);
            count <= count + (accept ? n_acc : '0) - n_cm;
            for (int i = 0; i < NFIN; i++) begin
                if (io.fin_valid[i] && in_window(io.fin_tag[i*IW +: IW])) begin
                    finish[io.fin_tag[i*IW +: IW]] <= 1'b1;
                    exc[io.fin_tag[i*IW +: IW]]    <= io.fin_exc[i];
                end
            end
            if (io.br_valid && in_window(io.br_tag)) begin
                finish[io.br_tag] <= 1'b1;
                brcond[io.br_tag] <= io.br_taken;
            end
            // Dispatch is written last so it wins any same-index collision.
            if (accept) begin
                for (int k = 0; k < DPW; k++) begin
                    if (io.dp_valid[k]) begin
                        finish[didx[k]] <= 1'b0;
                        exc[didx[k]]    <= 1'b0;
                        brcond[didx[k]] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (io.br_valid && !io.flush && in_window(io.br_tag)) begin
            jmpaddr[io.br_tag] <= io.br_target;
        end
        if (accept) begin
            for (int k = 0; k < DPW; k++) begin
                if (io.dp_valid[k]) begin
                    pc[didx[k]]       <= io.dp_pc[k*ADDR_LEN +: ADDR_LEN];
                    dst[didx[k]]      <= io.dp_dst[k*REG_SEL +: REG_SEL];
                    dstvalid[didx[k]] <= io.dp_dstvalid[k];
                    isstore[didx[k]]  <= io.dp_isstore[k];
                    isbranch[didx[k]] <= io.dp_isbranch[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH=8, DPW=2, CMW=2) checked every cycle against
// a queue-based model of the occupied window plus hand-computed literal expectations.
module tb_rob_param;
    logic clk;
    logic reset_n;

    rob_param_if #(.DEPTH(8), .DPW(2), .CMW(2), .NFIN(5), .REG_SEL(5), .ADDR_LEN(32)) bus ();

    rob_param #(.DEPTH(8), .DPW(2), .CMW(2), .NFIN(5), .REG_SEL(5), .ADDR_LEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fin;
        logic        exc;
        logic        dv;
        logic        st;
        logic        br;
        logic        tk;
        logic [4:0]  dst;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   mhead;
    int   pass_cnt;
    int   tot_cnt;
    int   seq;
    logic chk_en;

    int          e_count;
    int          e_tail;
    int          e_ncm;
    logic [1:0]  e_cmv;
    logic [5:0]  e_cmtag;
    logic [1:0]  e_we;
    logic [9:0]  e_dst;
    logic        e_store;
    logic        e_branch;
    logic [31:0] e_brpc;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_excv;
    logic [31:0] e_excpc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Expected outputs from the occupied window and the current flush input.
    task automatic model_eval();
        logic open;
        e_count = q.size();
        e_tail  = (mhead + e_count) % 8;
        e_excv  = (e_count > 0) && q[0].fin && q[0].exc;
        e_excpc = e_excv ? q[0].pc : 32'h0;
        e_cmv = '0; e_cmtag = '0; e_we = '0; e_dst = '0; e_ncm = 0;
        e_store = 0; e_branch = 0; e_brpc = '0; e_tk = 0; e_tgt = '0;
        open = !bus.flush && !e_excv;
        for (int i = 0; i < 2; i++) begin
            if (open && i < e_count && q[i].fin && !q[i].exc) begin
                e_cmv[i]         = 1'b1;
                e_cmtag[i*3 +: 3] = 3'((mhead + i) % 8);
                e_we[i]          = q[i].dv;
                e_dst[i*5 +: 5]  = q[i].dst;
                e_ncm++;
                if (q[i].st) begin e_store = 1'b1; open = 1'b0; end
                if (q[i].br) begin
                    e_branch = 1'b1; e_brpc = q[i].pc; e_tk = q[i].tk; e_tgt = q[i].tgt; open = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_eval();
            chk("count", 64'(bus.count), 64'(e_count));
            chk("empty", 64'(bus.empty), 64'(e_count == 0));
            chk("dp_ready", 64'(bus.dp_ready), 64'(e_count <= 6));
            chk("dp_tag", 64'(bus.dp_tag), 64'({3'(e_tail + 1), 3'(e_tail)}));
            chk("cm_valid", 64'(bus.cm_valid), 64'(e_cmv));
            chk("cm_store", 64'(bus.cm_store), 64'(e_store));
            chk("cm_branch", 64'(bus.cm_branch), 64'(e_branch));
            chk("cm_br_pc", 64'(bus.cm_br_pc), 64'(e_brpc));
            chk("cm_br_taken", 64'(bus.cm_br_taken), 64'(e_tk));
            chk("cm_br_target", 64'(bus.cm_br_target), 64'(e_tgt));
            chk("exc_valid", 64'(bus.exc_valid), 64'(e_excv));
            for (int k = 0; k < 2; k++) begin
                if (e_cmv[k]) begin
                    chk("cm_tag", 64'(bus.cm_tag[k*3 +: 3]), 64'(e_cmtag[k*3 +: 3]));
                    chk("cm_we", 64'(bus.cm_we[k]), 64'(e_we[k]));
                    chk("cm_dst", 64'(bus.cm_dst[k*5 +: 5]), 64'(e_dst[k*5 +: 5]));
                end
            end
            if (e_excv) begin
                chk("exc_tag", 64'(bus.exc_tag), 64'(3'(mhead)));
                chk("exc_pc", 64'(bus.exc_pc), 64'(e_excpc));
            end
        end
    end

    int   m_sz;
    int   m_off;
    logic m_rdy;
    ent_t m_t;

    always @(posedge clk) begin
        if (chk_en && reset_n) begin
            model_eval();
            if (bus.flush) begin
                q.delete();
            end else begin
                m_sz  = q.size();
                m_rdy = (m_sz <= 6);
                for (int p = 0; p < 5; p++) begin
                    if (bus.fin_valid[p]) begin
                        m_off = (int'(bus.fin_tag[p*3 +: 3]) - mhead + 8) % 8;
                        if (m_off < m_sz) begin
                            m_t = q[m_off]; m_t.fin = 1'b1; m_t.exc = bus.fin_exc[p]; q[m_off] = m_t;
                        end
                    end
                end
                if (bus.br_valid) begin
                    m_off = (int'(bus.br_tag) - mhead + 8) % 8;
                    if (m_off < m_sz) begin
                        m_t = q[m_off]; m_t.fin = 1'b1; m_t.tk = bus.br_taken; m_t.tgt = bus.br_target;
                        q[m_off] = m_t;
                    end
                end
                for (int i = 0; i < e_ncm; i++) void'(q.pop_front());
                mhead = (mhead + e_ncm) % 8;
                if (m_rdy) begin
                    for (int k = 0; k < 2; k++) begin
                        if (bus.dp_valid[k]) begin
                            m_t = '0;
                            m_t.dv  = bus.dp_dstvalid[k];
                            m_t.st  = bus.dp_isstore[k];
                            m_t.br  = bus.dp_isbranch[k];
                            m_t.dst = bus.dp_dst[k*5 +: 5];
                            m_t.pc  = bus.dp_pc[k*32 +: 32];
                            q.push_back(m_t);
                        end
                    end
                end
            end
        end
    end

    task automatic idle();
        bus.dp_valid = '0; bus.dp_pc = '0; bus.dp_dst = '0;
        bus.dp_dstvalid = '0; bus.dp_isstore = '0; bus.dp_isbranch = '0;
        bus.fin_valid = '0; bus.fin_tag = '0; bus.fin_exc = '0;
        bus.br_valid = 1'b0; bus.br_tag = '0; bus.br_taken = 1'b0; bus.br_target = '0;
        bus.flush = 1'b0;
    endtask

    task automatic disp(input int n, input logic [1:0] st, input logic [1:0] br);
        for (int k = 0; k < n; k++) begin
            bus.dp_valid[k]        = 1'b1;
            bus.dp_pc[k*32 +: 32]  = 32'h1000 + 32'(seq * 4);
            bus.dp_dst[k*5 +: 5]   = 5'(seq + 1);
            bus.dp_dstvalid[k]     = !st[k] && !br[k];
            bus.dp_isstore[k]      = st[k];
            bus.dp_isbranch[k]     = br[k];
            seq++;
        end
    endtask

    task automatic fin(input int p, input int tag, input logic ex);
        bus.fin_valid[p]       = 1'b1;
        bus.fin_tag[p*3 +: 3]  = 3'(tag);
        bus.fin_exc[p]         = ex;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    initial begin
        pass_cnt = 0; tot_cnt = 0; seq = 0; mhead = 0; chk_en = 1'b0;
        idle();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 chk_en = 1'b1;
        sample();
        chk("rst_ready", 64'(bus.dp_ready), 64'd1);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_cm_valid", 64'(bus.cm_valid), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // two ALU ops, tag1 finishes first: nothing commits until tag0 is done
        disp(2, 2'b00, 2'b00);
        sample(); chk("s1_dptag", 64'(bus.dp_tag), 64'h08); adv();
        fin(0, 1, 1'b0); cyc();
        sample(); chk("s1_nocm", 64'(bus.cm_valid), 64'd0); chk("s1_cnt2a", 64'(bus.count), 64'd2); adv();
        fin(0, 0, 1'b0); cyc();
        sample(); chk("s1_cm11", 64'(bus.cm_valid), 64'd3); chk("s1_cnt2", 64'(bus.count), 64'd2); adv();
        sample(); chk("s1_cnt0", 64'(bus.count), 64'd0); adv();

        // store then ALU: store closes the first commit group
        disp(2, 2'b01, 2'b00); cyc();
        fin(0, 2, 1'b0); fin(1, 3, 1'b0); cyc();
        sample(); chk("s2_cmv1", 64'(bus.cm_valid), 64'd1); chk("s2_st1", 64'(bus.cm_store), 64'd1);
        chk("s2_tag1", 64'(bus.cm_tag[2:0]), 64'd2); adv();
        sample(); chk("s2_cmv2", 64'(bus.cm_valid), 64'd1); chk("s2_st2", 64'(bus.cm_store), 64'd0);
        chk("s2_tag2", 64'(bus.cm_tag[2:0]), 64'd3); adv();

        // fill to full, commit while a dispatch is refused
        for (int i = 0; i < 4; i++) begin
            disp(2, 2'b00, 2'b00); cyc();
        end
        fin(0, 4, 1'b0); fin(1, 5, 1'b0);
        sample(); chk("s3_full_cnt", 64'(bus.count), 64'd8); chk("s3_full_rdy", 64'(bus.dp_ready), 64'd0); adv();
        disp(2, 2'b00, 2'b00);
        sample(); chk("s3_cm11", 64'(bus.cm_valid), 64'd3); adv();
        sample(); chk("s3_cnt6", 64'(bus.count), 64'd6); chk("s3_rdy", 64'(bus.dp_ready), 64'd1); adv();
        fin(0, 6, 1'b0); fin(1, 7, 1'b0); fin(2, 0, 1'b0); fin(3, 1, 1'b0); fin(4, 2, 1'b0); cyc();
        fin(0, 3, 1'b0); cyc();
        repeat (3) cyc();
        sample(); chk("s3_drained", 64'(bus.count), 64'd0); adv();

        // move head to 7, then dispatch across the wrap with a taken branch in lane 1
        disp(2, 2'b00, 2'b00); cyc();
        disp(1, 2'b00, 2'b00); cyc();
        fin(0, 4, 1'b0); fin(1, 5, 1'b0); fin(2, 6, 1'b0); cyc();
        repeat (2) cyc();
        disp(2, 2'b00, 2'b10);
        sample(); chk("s4_dptag", 64'(bus.dp_tag), 64'h07); adv();
        fin(0, 7, 1'b0);
        bus.br_valid = 1'b1; bus.br_tag = 3'd0; bus.br_taken = 1'b1; bus.br_target = 32'hABCD_0000;
        cyc();
        sample(); chk("s4_cm11", 64'(bus.cm_valid), 64'd3); chk("s4_cmtag", 64'(bus.cm_tag), 64'h07);
        chk("s4_br", 64'(bus.cm_branch), 64'd1); chk("s4_tgt", 64'(bus.cm_br_target), 64'hABCD_0000); adv();
        sample(); chk("s4_head1", 64'(bus.dp_tag[2:0]), 64'd1); adv();

        // exception at head blocks commit until flush; flush also drops dispatch
        disp(2, 2'b00, 2'b00); cyc();
        fin(0, 1, 1'b1); fin(1, 2, 1'b0); cyc();
        for (int i = 0; i < 3; i++) begin
            sample(); chk("s5_excv", 64'(bus.exc_valid), 64'd1); chk("s5_exctag", 64'(bus.exc_tag), 64'd1);
            chk("s5_nocm", 64'(bus.cm_valid), 64'd0); adv();
        end
        bus.flush = 1'b1; disp(2, 2'b00, 2'b00); cyc();
        sample(); chk("s5_cnt0", 64'(bus.count), 64'd0); chk("s5_excv0", 64'(bus.exc_valid), 64'd0);
        chk("s5_tail", 64'(bus.dp_tag[2:0]), 64'd1); adv();
        disp(2, 2'b00, 2'b00); fin(0, 1, 1'b0); fin(1, 2, 1'b0); cyc();
        sample(); chk("s5_dpwins", 64'(bus.cm_valid), 64'd0); adv();
        fin(0, 1, 1'b0); fin(1, 2, 1'b0); cyc();
        sample(); chk("s5_cm11", 64'(bus.cm_valid), 64'd3); adv();

        // asynchronous reset with five entries in flight
        disp(2, 2'b00, 2'b00); cyc();
        disp(2, 2'b00, 2'b00); cyc();
        disp(1, 2'b00, 2'b00); cyc();
        sample(); chk("s6_cnt5", 64'(bus.count), 64'd5); adv();
        #2 reset_n = 1'b0; q.delete(); mhead = 0;
        #1 chk("s6_async_cnt", 64'(bus.count), 64'd0); chk("s6_async_empty", 64'(bus.empty), 64'd1);
        @(posedge clk); #1 reset_n = 1'b1;
        disp(1, 2'b00, 2'b00);
        sample(); chk("s6_restart_tag", 64'(bus.dp_tag[2:0]), 64'd0); chk("s6_nocm", 64'(bus.cm_valid), 64'd0); adv();
        fin(0, 0, 1'b0); cyc();
        sample(); chk("s6_cm", 64'(bus.cm_valid), 64'd1); adv();
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
